// File: rtl/node_sink_pkg.sv
// node_sink_pkg: shared packet, phase and statistic definitions for the node ejection sink.
// Provides packet_t, sink_phase_t, STAT_W and a saturating increment helper.
package node_sink_pkg;
   localparam int STAT_W  = 32;
   localparam int COORD_W = 4;
   typedef struct packed {
      logic               ant;
      logic               backward;
      logic [COORD_W-1:0] x_source, y_source;
      logic [COORD_W-1:0] x_dest, y_dest;
      logic [15:0]        payload;
   } packet_t;
   typedef enum logic [1:0] {WARMUP, MEASURE, DRAIN, DONE} sink_phase_t;
   // Statistics stick at all-ones instead of wrapping.
   function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic inc);
      return (inc && v != '1) ? v + 1'b1 : v;
   endfunction
endpackage

// File: rtl/node_sink_lfsr_en_gen.sv
// lfsr_en_gen: pseudo-random registered enable with a programmable duty cycle.
// Ports: clk, reset_n (async, active-low), o_en (registered enable).
module lfsr_en_gen #(
   parameter logic [15:0] SEED    = 16'hACE1,
   parameter int          EN_RATE = 100
) (
   input  logic clk,
   input  logic reset_n,
   output logic o_en
);
   localparam logic [7:0] EN_THR = 8'((EN_RATE * 128) / 100);
   logic [15:0] lfsr_q, lfsr_d;
   logic        en_d;
   // Fibonacci x^16+x^14+x^13+x^11+1, shifting towards the MSB.
   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      en_d   = {1'b0, lfsr_q[15:9]} < EN_THR;
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lfsr_q <= SEED;
         o_en   <= 1'b0;
      end else begin
         lfsr_q <= lfsr_d;
         o_en   <= en_d;
      end
   end
endmodule

// File: rtl/node_sink.sv
// node_sink: per-node ejection endpoint sequencing warm-up/measure/drain and checking deliveries.
// Ports: clk, reset_n (async, active-low), i_data/i_data_val (network output), o_en (network enable),
// o_phase/o_done (run phase), o_rx/meas/ant/misroute_count, o_src_sig, o_error (sticky).
module node_sink
   import node_sink_pkg::*;
#(
   parameter int          X_ID            = 0,
   parameter int          Y_ID            = 0,
   parameter int          WARMUP_PACKETS  = 1000,
   parameter int          MEASURE_PACKETS = 5000,
   parameter int          DRAIN_PACKETS   = 3000,
   parameter int          EN_RATE         = 100,
   parameter logic [15:0] SEED            = 16'hACE1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  packet_t           i_data,
   input  logic              i_data_val,
   output logic              o_en,
   output sink_phase_t       o_phase,
   output logic              o_done,
   output logic [STAT_W-1:0] o_rx_count,
   output logic [STAT_W-1:0] o_meas_count,
   output logic [STAT_W-1:0] o_ant_count,
   output logic [STAT_W-1:0] o_misroute_count,
   output logic [15:0]       o_src_sig,
   output logic              o_error
);
   localparam logic [COORD_W-1:0] X_C = COORD_W'(X_ID);
   localparam logic [COORD_W-1:0] Y_C = COORD_W'(Y_ID);
   localparam logic [STAT_W-1:0]  W_L = STAT_W'(WARMUP_PACKETS);
   localparam logic [STAT_W-1:0]  M_L = STAT_W'(MEASURE_PACKETS);
   localparam logic [STAT_W-1:0]  D_L = STAT_W'(DRAIN_PACKETS);

   sink_phase_t       phase_q, phase_d;
   logic [STAT_W-1:0] pcnt_q, pcnt_d, rx_q, rx_d, meas_q, meas_d, ant_q, ant_d, mis_q, mis_d, lim;
   logic [15:0]       sig_q, sig_d;
   logic              err_q, err_d, accept, dest_ok, good, in_meas, adv;

   lfsr_en_gen #(.SEED(SEED), .EN_RATE(EN_RATE)) u_en (
      .clk    (clk),
      .reset_n(reset_n),
      .o_en   (o_en)
   );

   always_comb begin
      accept  = i_data_val && o_en;
      dest_ok = i_data.x_dest == X_C && i_data.y_dest == Y_C;
      good    = accept && !i_data.ant && dest_ok;
      in_meas = good && phase_q == MEASURE;
      lim     = phase_q == WARMUP ? W_L : phase_q == MEASURE ? M_L : D_L;
      // A zero limit leaves the phase unconditionally, giving one skipped phase per cycle.
      adv     = phase_q != DONE && (lim == '0 || (good && pcnt_q == lim - 1'b1));
      phase_d = adv ? sink_phase_t'(phase_q + 2'd1) : phase_q;
      pcnt_d  = (adv || phase_q == DONE) ? '0 : pcnt_q + STAT_W'(good);
      rx_d    = sat_inc(rx_q, accept);
      ant_d   = sat_inc(ant_q, accept && i_data.ant);
      mis_d   = sat_inc(mis_q, accept && !dest_ok);
      meas_d  = sat_inc(meas_q, in_meas);
      sig_d   = in_meas ? sig_q ^ 16'({i_data.x_source, i_data.y_source}) : sig_q;
      err_d   = err_q || (accept && !dest_ok) || (i_data_val && !o_en);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= WARMUP;
         pcnt_q  <= '0;
         rx_q    <= '0;
         meas_q  <= '0;
         ant_q   <= '0;
         mis_q   <= '0;
         sig_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         pcnt_q  <= pcnt_d;
         rx_q    <= rx_d;
         meas_q  <= meas_d;
         ant_q   <= ant_d;
         mis_q   <= mis_d;
         sig_q   <= sig_d;
         err_q   <= err_d;
      end
   end

   assign o_phase          = phase_q;
   assign o_done           = phase_q == DONE;
   assign o_rx_count       = rx_q;
   assign o_meas_count     = meas_q;
   assign o_ant_count      = ant_q;
   assign o_misroute_count = mis_q;
   assign o_src_sig        = sig_q;
   assign o_error          = err_q;
endmodule

// File: tb/tb_node_sink.sv
// tb_node_sink: randomized and directed checking of node_sink against a behavioural model.
module tb_node_sink;
   import node_sink_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   packet_t     i_data = '0;
   logic        i_data_val = 1'b0;
   logic        en[3], done[3], err[3];
   sink_phase_t ph[3];
   logic [31:0] rx[3], meas[3], ant[3], mis[3];
   logic [15:0] sig[3];

   always #5 clk = ~clk;

   // u0: rate 100, limits 2/3/1; u1: rate 0, all limits 0; u2: rate 50, limits 5/20/5.
   for (genvar g = 0; g < 3; g++) begin : g_dut
      node_sink #(
         .X_ID(1), .Y_ID(2),
         .WARMUP_PACKETS (g == 0 ? 2 : g == 1 ? 0 : 5),
         .MEASURE_PACKETS(g == 0 ? 3 : g == 1 ? 0 : 20),
         .DRAIN_PACKETS  (g == 0 ? 1 : g == 1 ? 0 : 5),
         .EN_RATE        (g == 0 ? 100 : g == 1 ? 0 : 50),
         .SEED(16'hACE1)
      ) dut (
         .clk(clk), .reset_n(reset_n), .i_data(i_data), .i_data_val(i_data_val),
         .o_en(en[g]), .o_phase(ph[g]), .o_done(done[g]), .o_rx_count(rx[g]),
         .o_meas_count(meas[g]), .o_ant_count(ant[g]), .o_misroute_count(mis[g]),
         .o_src_sig(sig[g]), .o_error(err[g])
      );
   end

   int LIM[3][3] = '{'{2, 3, 1}, '{0, 0, 0}, '{5, 20, 5}};
   int RATE[3]   = '{100, 0, 50};

   int          m_ph[3], m_pc[3];
   logic [31:0] m_rx[3], m_meas[3], m_ant[3], m_mis[3];
   logic [15:0] m_sig[3], m_lf[3];
   bit          m_en[3], m_err[3];

   int  n_vec = 0, n_err = 0, since = 0;
   bit  captured = 0;
   bit  first_seq[200];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sat(input logic [31:0] v);
      return v == 32'hFFFF_FFFF ? v : v + 1;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         m_ph[k] = 0; m_pc[k] = 0; m_rx[k] = 0; m_meas[k] = 0; m_ant[k] = 0; m_mis[k] = 0;
         m_sig[k] = 0; m_lf[k] = 16'hACE1; m_en[k] = 0; m_err[k] = 0;
      end
   endtask

   task automatic model_step(input int k);
      bit acc, dok, good;
      acc  = i_data_val && m_en[k];
      dok  = i_data.x_dest == 4'd1 && i_data.y_dest == 4'd2;
      good = acc && !i_data.ant && dok;
      if (acc) begin
         m_rx[k] = sat(m_rx[k]);
         if (i_data.ant) m_ant[k] = sat(m_ant[k]);
         if (!dok) begin m_mis[k] = sat(m_mis[k]); m_err[k] = 1; end
      end
      if (i_data_val && !m_en[k]) m_err[k] = 1;
      if (good && m_ph[k] == 1) begin
         m_meas[k] = sat(m_meas[k]);
         m_sig[k]  = m_sig[k] ^ {8'h00, i_data.x_source, i_data.y_source};
      end
      if (m_ph[k] < 3) begin
         if (LIM[k][m_ph[k]] == 0) begin m_ph[k]++; m_pc[k] = 0; end
         else if (good) begin
            m_pc[k]++;
            if (m_pc[k] == LIM[k][m_ph[k]]) begin m_ph[k]++; m_pc[k] = 0; end
         end
      end
      m_en[k] = int'(m_lf[k][15:9]) < (RATE[k] * 128) / 100;
      m_lf[k] = {m_lf[k][14:0], ^(m_lf[k] & 16'hB400)};
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("u%0d.en", k), en[k], m_en[k]);
         chk($sformatf("u%0d.phase", k), ph[k], m_ph[k]);
         chk($sformatf("u%0d.done", k), done[k], m_ph[k] == 3);
         chk($sformatf("u%0d.rx", k), rx[k], m_rx[k]);
         chk($sformatf("u%0d.meas", k), meas[k], m_meas[k]);
         chk($sformatf("u%0d.ant", k), ant[k], m_ant[k]);
         chk($sformatf("u%0d.mis", k), mis[k], m_mis[k]);
         chk($sformatf("u%0d.sig", k), sig[k], m_sig[k]);
         chk($sformatf("u%0d.err", k), err[k], m_err[k]);
      end
   endtask

   // Drive one cycle at the falling edge, update the model at the rising edge, check at the next fall.
   task automatic cyc(input packet_t p, input logic v);
      i_data = p;
      i_data_val = v;
      @(posedge clk);
      if (reset_n) for (int k = 0; k < 3; k++) model_step(k);
      @(negedge clk);
      check_all();
      if (since < 200) begin
         if (captured) chk("repeat_en", en[2], first_seq[since]);
         else first_seq[since] = en[2];
      end
      since++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst.en", en[0], 0);
      chk("rst.phase", ph[0], WARMUP);
      chk("rst.rx", rx[0], 0);
      @(negedge clk);
      check_all();
      reset_n = 1'b1;
      if (since >= 200) captured = 1;
      since = 0;
   endtask

   function automatic packet_t mk(input bit a, input int xs, input int ys, input int xd, input int yd);
      packet_t p;
      p = '0;
      p.ant = a; p.backward = 1'($urandom);
      p.x_source = 4'(xs); p.y_source = 4'(ys); p.x_dest = 4'(xd); p.y_dest = 4'(yd);
      p.payload = 16'($urandom);
      return p;
   endfunction

   function automatic packet_t rnd_pkt();
      bit ok;
      ok = $urandom_range(7) != 0;
      return mk($urandom_range(7) == 0, $urandom_range(15), $urandom_range(15),
                ok ? 1 : $urandom_range(15), ok ? 2 : $urandom_range(15));
   endfunction

   int duty;
   initial begin
      model_reset();
      do_reset();
      // Six good packets: phase changes after packets 2, 5 and 6.
      cyc('0, 0);
      cyc(mk(0, 5, 5, 1, 2), 1);
      cyc(mk(0, 5, 5, 1, 2), 1);
      chk("seq.phase2", ph[0], MEASURE);
      cyc(mk(0, 0, 1, 1, 2), 1);
      cyc(mk(0, 2, 3, 1, 2), 1);
      cyc(mk(0, 0, 1, 1, 2), 1);
      chk("seq.phase5", ph[0], DRAIN);
      chk("seq.sig", sig[0], 16'h0023);
      chk("seq.meas", meas[0], 3);
      cyc(mk(0, 5, 5, 1, 2), 1);
      chk("seq.phase6", ph[0], DONE);
      chk("seq.done", done[0], 1);
      chk("seq.rx", rx[0], 6);
      chk("u1.skip_done", ph[1], DONE);
      // Ant packets and a misroute never advance the phase.
      do_reset();
      cyc('0, 0);
      for (int i = 0; i < 4; i++) cyc(mk(1, 3, 3, 1, 2), 1);
      cyc(mk(0, 3, 3, 0, 0), 1);
      chk("ant.count", ant[0], 4);
      chk("ant.mis", mis[0], 1);
      chk("ant.err", err[0], 1);
      chk("ant.phase", ph[0], WARMUP);
      chk("ant.rx", rx[0], 5);
      chk("rate0.en", en[1], 0);
      chk("rate0.rx", rx[1], 0);
      chk("rate0.err", err[1], 1);
      // Long random run; also measures the duty cycle of the 50% instance.
      do_reset();
      duty = 0;
      for (int i = 0; i < 10000; i++) begin
         cyc(rnd_pkt(), $urandom_range(3) != 0);
         duty += int'(en[2]);
      end
      chk("duty.lo", duty >= 4500, 1);
      chk("duty.hi", duty <= 5500, 1);
      // Reset in the middle of MEASURE, then restart from zero.
      do_reset();
      cyc('0, 0);
      for (int i = 0; i < 3; i++) cyc(mk(0, 1, 1, 1, 2), 1);
      chk("mid.phase", ph[0], MEASURE);
      do_reset();
      chk("mid.rst_meas", meas[0], 0);
      cyc('0, 0);
      cyc(mk(0, 1, 1, 1, 2), 1);
      cyc(mk(0, 1, 1, 1, 2), 1);
      chk("mid.restart_phase", ph[0], MEASURE);
      chk("mid.restart_meas", meas[0], 0);
      chk("mid.restart_rx", rx[0], 2);
      for (int i = 0; i < 250; i++) cyc(rnd_pkt(), $urandom_range(3) != 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/node_sink.md
# node_sink

Synthesizable per-node ejection endpoint on the network output side: it consumes `o_data`/`o_data_val` for one node and drives that node's `i_en` back into the network. It sequences the warm-up/measure/drain run phases by counting delivered packets, checks every delivery for destination correctness and flow-control legality, and exports run statistics. One instance is generated per node, and each instance replaces the open-loop receive logic that drives `i_en`.

## Interface

Parameters:
- `X_ID`, default 0: X coordinate of this node.
- `Y_ID`, default 0: Y coordinate of this node.
- `WARMUP_PACKETS`, default 1000: data packets accepted before measurement starts.
- `MEASURE_PACKETS`, default 5000: data packets counted in the measurement window.
- `DRAIN_PACKETS`, default 3000: data packets accepted after measurement before the run reports done.
- `EN_RATE`, default 100: percentage (0–100) of cycles on which `o_en` is asserted.
- `SEED`, default 16'hACE1: LFSR reset value. Must be nonzero.

Ports:
- `clk`, in, 1: clock. One clock domain.
- `reset_n`, in, 1: reset, asynchronous and active-low.
- `i_data`, in, `packet_t`: packet from the network output for this node.
- `i_data_val`, in, 1: `i_data` is valid.
- `o_en`, out, 1: enable to the network (drives the network's `i_en[n]`).
- `o_phase`, out, `sink_phase_t`: current run phase.
- `o_done`, out, 1: high when `o_phase` is DONE.
- `o_rx_count`, out, 32: all accepted packets, data and ant.
- `o_meas_count`, out, 32: data packets accepted during MEASURE.
- `o_ant_count`, out, 32: accepted packets with `ant=1`.
- `o_misroute_count`, out, 32: accepted packets whose destination is not (X_ID, Y_ID).
- `o_src_sig`, out, 16: XOR signature of the sources of MEASURE packets.
- `o_error`, out, 1: sticky error flag.

## Operation

- A packet is accepted when `i_data_val && o_en`.
- A good data packet is one that is accepted, has `ant=0`, and has `x_dest==X_ID && y_dest==Y_ID`. Only good data packets advance the phase counter.
- Phase FSM, with states WARMUP → MEASURE → DRAIN → DONE:
  - A single 32-bit phase counter `pcnt` counts good data packets within the current phase.
  - A transition happens on the edge where `pcnt` reaches its phase limit; `pcnt` clears to 0 on that edge.
  - A limit of 0 skips the phase on the first cycle after reset. Phases are skipped in sequence, one per cycle.
  - DONE is absorbing until reset. Acceptance and statistics continue in DONE, except `o_meas_count` and `o_src_sig`.
- Ant packets (`ant=1`) increment `o_ant_count` and `o_rx_count`. They never advance the phase, whatever their `backward` value.
- Misroute: an accepted packet with the wrong destination increments `o_misroute_count` and `o_rx_count`, and sets `o_error`. It does not advance the phase.
- Flow violation: `i_data_val=1` while `o_en=0` sets `o_error`. The packet is not counted.
- MEASURE only: on each good data packet, `o_src_sig <= o_src_sig ^ {x_source, y_source}`, zero-extended to 16 bits. `o_meas_count` also increments.
- All statistic counters saturate at 32'hFFFF_FFFF and do not wrap.
- Enable generation:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, advancing every cycle after reset.
  - `o_en <= (lfsr[15:9] < EN_THR)`, where `EN_THR = (EN_RATE*128)/100` is 8 bits wide.
  - `EN_RATE=100` gives `EN_THR=128`, so `o_en` is always 1 out of reset. `EN_RATE=0` gives `o_en` always 0.

## Timing

- Reset values:
  - `o_en=0`, `o_phase=WARMUP`, `o_done=0`, `o_error=0`.
  - All counters 0, `o_src_sig=0`, LFSR = `SEED`.
- `o_en` is registered. It first rises on the first `clk` edge after `reset_n` deasserts. `o_en` in cycle t is decided at edge t−1.
- Acceptance is sampled at edge t using `o_en` and `i_data_val` as they stand in cycle t. Every counter, `o_phase`, `o_done` and `o_src_sig` reflect that packet after edge t (one-cycle latency).
- The packet that completes a phase is attributed to the old phase. Example: the MEASURE_PACKETS-th MEASURE packet is included in `o_meas_count`, and `o_phase=DRAIN` in the following cycle.
- Simultaneous misroute and ant: both counters increment. `o_rx_count` increments by 1 only.
- Asynchronous reset mid-run returns every register to its reset value immediately; there is no partial-phase retention.

## Structure

- Shared package (alongside `packet_t`):
  - `typedef enum logic [1:0] {WARMUP, MEASURE, DRAIN, DONE} sink_phase_t`.
  - 32-bit statistic-width constant.
- Sub-module `lfsr_en_gen`: parameters `SEED`, `EN_RATE`; ports `clk`, `reset_n`, `o_en`. It contains the LFSR and the threshold compare.
- `node_sink` contains the FSM, the acceptance/classification logic and the counters.

## Test plan

- EN_RATE=100, limits 2/3/1, X_ID=1, Y_ID=2; send 6 back-to-back good packets → phases WARMUP, MEASURE, DRAIN, DONE after packets 2, 5 and 6; `o_meas_count=3`, `o_done=1`, `o_rx_count=6`.
- Send 3 MEASURE packets from sources (0,1), (2,3), (0,1) → `o_src_sig` equals the `{x_source, y_source}` of (2,3); `o_meas_count=3`.
- Send 4 packets with `ant=1` plus 1 with dest (0,0) to node (1,2) → `o_ant_count=4`, `o_misroute_count=1`, `o_error=1`, phase still WARMUP, `pcnt=0`.
- EN_RATE=0; drive `i_data_val=1` → `o_en` stays 0, no counter moves, `o_error=1` next cycle.
- EN_RATE=50, 10000 cycles → `o_en` duty cycle between 45% and 55%; the sequence repeats identically for the same `SEED`.
- Assert `reset_n=0` mid-MEASURE → all outputs at reset values while reset is low; after release, phase is WARMUP and counting restarts from 0.
